// File: rtl/fir_pkg.sv
// Shared parameters, FSM state type and output saturation for the FIR.
// Imported by fir_mac and fir_ring_filter.
package fir_pkg;

    localparam int TAPS      = 64;
    localparam int SAMPLE_W  = 16;
    localparam int COEFF_W   = 10;
    localparam int ACC_W     = 32;
    localparam int OUT_SHIFT = 9;
    localparam int IDX_W     = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(32768);

    // Scale the Q1.9-weighted sum back to sample units and clamp to 16 bits.
    function automatic logic signed [SAMPLE_W-1:0] sat16(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > SAT_HI)
            s = SAT_HI;
        else if (s < SAT_LO)
            s = SAT_LO;
        return s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with clear and enable.
// Ports: clk, rst (sync high), clr, en, coeff, sample in; acc out.
module fir_mac
    import fir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [COEFF_W-1:0]  coeff,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [COEFF_W+SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]            prod_ext;

    assign prod     = coeff * sample;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/fir_ring_filter.sv
// Sequential 64-tap FIR: owns the sample ring and write offset, one MAC/clk.
// Ports: clk_in, rst_in, ready_in, sample_in, coeffs_in in;
//        sample_buffer_out, offset_out, signal_out, done, overrun_out out.
module fir_ring_filter
    import fir_pkg::*;
(
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  ready_in,
    input  logic signed [SAMPLE_W-1:0]            sample_in,
    input  logic signed [TAPS-1:0][COEFF_W-1:0]   coeffs_in,
    output logic signed [TAPS-1:0][SAMPLE_W-1:0]  sample_buffer_out,
    output logic [IDX_W-1:0]                      offset_out,
    output logic signed [SAMPLE_W-1:0]            signal_out,
    output logic                                  done,
    output logic                                  overrun_out
);

    fir_state_t state_q;
    fir_state_t state_d;

    logic [IDX_W-1:0]                     k_q;
    logic [IDX_W-1:0]                     offset_q;
    logic [IDX_W-1:0]                     next_off;
    logic [IDX_W-1:0]                     tap;
    logic [TAPS-1:0][SAMPLE_W-1:0]        buf_q;
    logic signed [SAMPLE_W-1:0]           signal_q;
    logic                                 done_q;
    logic                                 overrun_q;
    logic signed [ACC_W-1:0]              acc;

    logic accept;
    logic drop;
    logic mac_en;
    logic out_load;

    assign next_off = offset_q + 1'b1;
    // Newest sample pairs with coeff 0; 6-bit wrap walks back through the ring.
    assign tap      = offset_q - k_q;

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ready_in) state_d = MAC;
            MAC:     if (k_q == IDX_W'(TAPS-1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_q == IDLE) && ready_in;
        drop     = (state_q != IDLE) && ready_in;
        mac_en   = (state_q == MAC);
        out_load = (state_q == OUT);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            offset_q  <= IDX_W'(TAPS-1);
            buf_q     <= '0;
            k_q       <= '0;
            signal_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= out_load;
            overrun_q <= drop;
            if (accept) begin
                offset_q        <= next_off;
                buf_q[next_off] <= sample_in;
                k_q             <= '0;
            end
            if (mac_en)
                k_q <= k_q + 1'b1;
            if (out_load)
                signal_q <= sat16(acc);
        end
    end

    fir_mac u_mac (
        .clk    (clk_in),
        .rst    (rst_in),
        .clr    (accept),
        .en     (mac_en),
        .coeff  ($signed(coeffs_in[k_q])),
        .sample ($signed(buf_q[tap])),
        .acc    (acc)
    );

    assign sample_buffer_out = buf_q;
    assign offset_out        = offset_q;
    assign signal_out        = signal_q;
    assign done              = done_q;
    assign overrun_out       = overrun_q;

endmodule

// File: tb/tb_fir_ring_filter.sv
// Self-checking bench for fir_ring_filter against a sample-history model.
// Drives directed and random samples; prints one summary line.
module tb_fir_ring_filter;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic                       ready_in;
    logic signed [15:0]         sample_in;
    logic signed [63:0][9:0]    coeffs_in;
    logic signed [63:0][15:0]   sample_buffer_out;
    logic [5:0]                 offset_out;
    logic signed [15:0]         signal_out;
    logic                       done;
    logic                       overrun_out;

    int vectors = 0;
    int miscompares = 0;

    int cf[64];
    int hist[$];
    int moff;

    fir_ring_filter dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .ready_in          (ready_in),
        .sample_in         (sample_in),
        .coeffs_in         (coeffs_in),
        .sample_buffer_out (sample_buffer_out),
        .offset_out        (offset_out),
        .signal_out        (signal_out),
        .done              (done),
        .overrun_out       (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // hist[j] is the j-th most recent accepted sample (0 = newest).
    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 64; i++) hist.push_back(0);
        moff = 63;
    endtask

    task automatic model_push(input int s);
        hist.push_front(s);
        void'(hist.pop_back());
        moff = (moff + 1) % 64;
    endtask

    function automatic int model_out();
        longint a;
        a = 0;
        for (int k = 0; k < 64; k++)
            a += longint'(cf[k]) * longint'(hist[k]);
        a = a >>> 9;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return int'(a);
    endfunction

    function automatic int buf_exp(input int idx);
        return hist[(moff - idx + 64) % 64];
    endfunction

    task automatic load_coeffs();
        for (int k = 0; k < 64; k++) coeffs_in[k] = 10'(cf[k]);
    endtask

    task automatic do_reset();
        rst_in   = 1'b1;
        ready_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        model_reset();
    endtask

    // Accepting edge E0, then counts edges until done is seen (65 expected).
    task automatic send(input int s, output int lat);
        ready_in  = 1'b1;
        sample_in = 16'(s);
        tick();
        ready_in = 1'b0;
        model_push(s);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 64; k++) cf[k] = 0;
        load_coeffs();
        do_reset();
        vectors++;
        if (offset_out !== 6'd63) begin
            miscompares++;
            $display("FAIL reset_offset: got %0d want 63", offset_out);
        end
        vectors++;
        if (sample_buffer_out !== '0) begin
            miscompares++;
            $display("FAIL reset_buffer: got %h want 0", sample_buffer_out);
        end
        vectors++;
        if (signal_out !== 16'sd0 || done !== 1'b0 || overrun_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs: sig %0d done %b ovr %b want 0 0 0",
                     signal_out, done, overrun_out);
        end
    endtask

    task automatic test_passthrough();
        int lat;
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 0;
        cf[0] = 256;
        load_coeffs();
        send(1000, lat);
        vectors++;
        if (lat !== 65) begin
            miscompares++;
            $display("FAIL pass_latency: got %0d want 65", lat);
        end
        vectors++;
        if (signal_out !== 16'sd500) begin
            miscompares++;
            $display("FAIL pass_out: got %0d want 500", signal_out);
        end
        vectors++;
        if (offset_out !== 6'd0 || sample_buffer_out[0] !== 16'sd1000) begin
            miscompares++;
            $display("FAIL pass_ring: off %0d buf0 %0d want 0 1000",
                     offset_out, sample_buffer_out[0]);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || signal_out !== 16'sd500) begin
            miscompares++;
            $display("FAIL pass_hold: done %b sig %0d want 0 500",
                     done, signal_out);
        end
    endtask

    task automatic test_delay();
        int lat;
        int smp[4];
        int want[4];
        smp  = '{1000, 0, 0, 0};
        want = '{0, 0, 0, 500};
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 0;
        cf[3] = 256;
        load_coeffs();
        for (int i = 0; i < 4; i++) begin
            send(smp[i], lat);
            vectors++;
            if (lat !== 65 || signal_out !== 16'(want[i])) begin
                miscompares++;
                $display("FAIL delay_%0d: lat %0d out %0d want 65 %0d",
                         i, lat, signal_out, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 8;
        load_coeffs();
        for (int i = 0; i < 65; i++) begin
            send(i + 1, lat);
            vectors++;
            if (lat !== 65 || offset_out !== 6'(i % 64)
                || signal_out !== 16'(model_out())) begin
                miscompares++;
                $display("FAIL wrap_%0d: lat %0d off %0d out %0d want 65 %0d %0d",
                         i, lat, offset_out, signal_out, i % 64, model_out());
            end
        end
        vectors++;
        if (sample_buffer_out[0] !== 16'sd65 || signal_out !== 16'sd33) begin
            miscompares++;
            $display("FAIL wrap_final: buf0 %0d out %0d want 65 33",
                     sample_buffer_out[0], signal_out);
        end
        vectors++;
        if (sample_buffer_out[1] !== 16'(buf_exp(1))) begin
            miscompares++;
            $display("FAIL wrap_buf1: got %0d want %0d",
                     sample_buffer_out[1], buf_exp(1));
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 511;
        load_coeffs();
        for (int i = 0; i < 64; i++) begin
            send(32767, lat);
            vectors++;
            if (lat !== 65 || signal_out !== 16'(model_out())) begin
                miscompares++;
                $display("FAIL sat_pos_%0d: lat %0d out %0d want 65 %0d",
                         i, lat, signal_out, model_out());
            end
        end
        vectors++;
        if (signal_out !== 16'sd32767) begin
            miscompares++;
            $display("FAIL sat_pos_final: got %0d want 32767", signal_out);
        end
        for (int i = 0; i < 64; i++) begin
            send(-32768, lat);
            vectors++;
            if (lat !== 65 || signal_out !== 16'(model_out())) begin
                miscompares++;
                $display("FAIL sat_neg_%0d: lat %0d out %0d want 65 %0d",
                         i, lat, signal_out, model_out());
            end
        end
        vectors++;
        if (signal_out !== -16'sd32768) begin
            miscompares++;
            $display("FAIL sat_neg_final: got %0d want -32768", signal_out);
        end
    endtask

    task automatic test_overrun();
        int total;
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 0;
        cf[0] = 256;
        cf[1] = 128;
        load_coeffs();
        ready_in  = 1'b1;
        sample_in = 16'sd2000;
        tick();
        ready_in = 1'b0;
        model_push(2000);
        for (int n = 0; n < 9; n++) tick();
        ready_in  = 1'b1;
        sample_in = 16'sd1234;
        tick();
        ready_in = 1'b0;
        vectors++;
        if (overrun_out !== 1'b1 || offset_out !== 6'(moff)) begin
            miscompares++;
            $display("FAIL overrun_pulse: ovr %b off %0d want 1 %0d",
                     overrun_out, offset_out, moff);
        end
        tick();
        vectors++;
        if (overrun_out !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_width: got %b want 0", overrun_out);
        end
        total = 11;
        while (!done && total < 120) begin
            tick();
            total++;
        end
        vectors++;
        if (total !== 65 || signal_out !== 16'(model_out())
            || sample_buffer_out[1] !== 16'sd0) begin
            miscompares++;
            $display("FAIL overrun_result: lat %0d out %0d buf1 %0d want 65 %0d 0",
                     total, signal_out, sample_buffer_out[1], model_out());
        end
    endtask

    task automatic test_random();
        int lat;
        int s;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 64; k++) cf[k] = int'($urandom_range(0, 1023)) - 512;
            load_coeffs();
            for (int i = 0; i < 15; i++) begin
                s = int'($urandom_range(0, 65535)) - 32768;
                send(s, lat);
                vectors++;
                if (lat !== 65 || signal_out !== 16'(model_out())
                    || offset_out !== 6'(moff)) begin
                    miscompares++;
                    $display("FAIL rand_%0d_%0d: lat %0d out %0d off %0d want 65 %0d %0d",
                             r, i, lat, signal_out, offset_out, model_out(), moff);
                end
            end
        end
        vectors++;
        if (sample_buffer_out[7] !== 16'(buf_exp(7))) begin
            miscompares++;
            $display("FAIL rand_buf7: got %0d want %0d",
                     sample_buffer_out[7], buf_exp(7));
        end
    endtask

    task automatic test_reset_mid_mac();
        int lat;
        int seen;
        do_reset();
        for (int k = 0; k < 64; k++) cf[k] = 0;
        cf[0] = 256;
        load_coeffs();
        send(1000, lat);
        ready_in  = 1'b1;
        sample_in = 16'sd3000;
        tick();
        ready_in = 1'b0;
        for (int n = 0; n < 30; n++) tick();
        rst_in   = 1'b1;
        ready_in = 1'b1;
        tick();
        rst_in   = 1'b0;
        ready_in = 1'b0;
        model_reset();
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mac_done: got %0d pulses want 0", seen);
        end
        vectors++;
        if (signal_out !== 16'sd0 || offset_out !== 6'd63
            || sample_buffer_out !== '0) begin
            miscompares++;
            $display("FAIL rst_mac_state: out %0d off %0d buf0 %0d want 0 63 0",
                     signal_out, offset_out, sample_buffer_out[0]);
        end
        send(1000, lat);
        vectors++;
        if (lat !== 65 || signal_out !== 16'sd500 || offset_out !== 6'd0
            || sample_buffer_out[0] !== 16'sd1000) begin
            miscompares++;
            $display("FAIL rst_mac_after: lat %0d out %0d off %0d buf0 %0d want 65 500 0 1000",
                     lat, signal_out, offset_out, sample_buffer_out[0]);
        end
    endtask

    initial begin
        rst_in    = 1'b1;
        ready_in  = 1'b0;
        sample_in = '0;
        coeffs_in = '0;
        model_reset();
        test_reset();
        test_passthrough();
        test_delay();
        test_wrap();
        test_saturation();
        test_overrun();
        test_random();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
